// File: rtl/exp4_detector_jogada.sv
// exp4_detector_jogada: debounced play detector for a 4-button keypad.
// It synchronizes the raw button levels and filters presses and releases.
// A stable single-button press produces one jogada pulse and latches its one-hot value.
// A stable multi-button pattern produces one invalida pulse instead.
// Ports:
//   clock        - system clock, rising edge
//   reset        - asynchronous active-high reset
//   botoes       - raw asynchronous button levels (1 = pressed)
//   jogada       - one-cycle pulse for an accepted single-button press
//   jogada_valor - one-hot value of the last accepted press (registered)
//   invalida     - one-cycle pulse for a rejected multi-button pattern
//   db_estado    - debug state code
module exp4_detector_jogada #(
    parameter int unsigned DEBOUNCE = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    output logic       jogada,
    output logic [3:0] jogada_valor,
    output logic       invalida,
    output logic [3:0] db_estado
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

    typedef enum logic [2:0] {
        ESPERA        = 3'd0,
        FILTRANDO     = 3'd1,
        PULSO         = 3'd2,
        REJEITA       = 3'd3,
        ESPERA_SOLTAR = 3'd4
    } estado_t;

    estado_t          estado;
    logic [3:0]       sync1;
    logic [3:0]       botoes_s;
    logic [3:0]       padrao;
    logic [CNT_W-1:0] cnt;

    // Synchronizer, press/release filter and play-value register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1        <= 4'b0000;
            botoes_s     <= 4'b0000;
            estado       <= ESPERA;
            padrao       <= 4'b0000;
            cnt          <= '0;
            jogada_valor <= 4'b0000;
        end else begin
            sync1    <= botoes;
            botoes_s <= sync1;

            case (estado)
                ESPERA: begin
                    if (botoes_s != 4'b0000) begin
                        padrao <= botoes_s;
                        cnt    <= CNT_W'(1);
                        estado <= FILTRANDO;
                    end
                end

                FILTRANDO: begin
                    if (botoes_s == 4'b0000) begin
                        cnt    <= '0;
                        estado <= ESPERA;
                    end else if (botoes_s != padrao) begin
                        // pattern changed while filtering: restart on the new one
                        padrao <= botoes_s;
                        cnt    <= CNT_W'(1);
                    end else if (cnt < CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if ($onehot(padrao)) begin
                        jogada_valor <= padrao;
                        estado       <= PULSO;
                    end else begin
                        estado <= REJEITA;
                    end
                end

                PULSO, REJEITA: begin
                    cnt    <= '0;
                    estado <= ESPERA_SOLTAR;
                end

                ESPERA_SOLTAR: begin
                    // any activity restarts the release filter
                    if (botoes_s != 4'b0000) begin
                        cnt <= '0;
                    end else if (cnt < CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt    <= '0;
                        estado <= ESPERA;
                    end
                end

                default: begin
                    cnt    <= '0;
                    estado <= ESPERA;
                end
            endcase
        end
    end

    // Moore outputs decoded from the state register only
    always_comb begin
        jogada    = 1'b0;
        invalida  = 1'b0;
        db_estado = 4'hE;
        case (estado)
            ESPERA:        db_estado = 4'h0;
            FILTRANDO:     db_estado = 4'h1;
            PULSO: begin
                db_estado = 4'h2;
                jogada    = 1'b1;
            end
            REJEITA: begin
                db_estado = 4'h3;
                invalida  = 1'b1;
            end
            ESPERA_SOLTAR: db_estado = 4'h4;
            default:       db_estado = 4'hE;
        endcase
    end

endmodule

// File: tb/tb_exp4_detector_jogada.sv
// tb_exp4_detector_jogada: directed scenarios plus random button traffic for exp4_detector_jogada.
// The reference model tracks run lengths of the synchronized button samples.
module tb_exp4_detector_jogada;

    localparam int unsigned D = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] botoes;
    logic       jogada;
    logic [3:0] jogada_valor;
    logic       invalida;
    logic [3:0] db_estado;

    int checks   = 0;
    int failures = 0;
    int n_jog    = 0;
    int n_inv    = 0;

    // reference model: 0 = idle/filtering, 1 = event cycle, 2 = waiting for release
    logic [3:0] m_q1, m_q2, m_pat, m_val;
    int         m_phase, m_run, m_zrun;
    logic       m_jog, m_inv;

    exp4_detector_jogada #(.DEBOUNCE(D)) dut (
        .clock        (clock),
        .reset        (reset),
        .botoes       (botoes),
        .jogada       (jogada),
        .jogada_valor (jogada_valor),
        .invalida     (invalida),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] exp_db();
        if (m_phase == 0) return (m_run == 0) ? 4'h0 : 4'h1;
        if (m_phase == 1) return m_jog ? 4'h2 : 4'h3;
        return 4'h4;
    endfunction

    task automatic model_reset();
        m_q1 = 0; m_q2 = 0; m_pat = 0; m_val = 0;
        m_phase = 0; m_run = 0; m_zrun = 0;
        m_jog = 0; m_inv = 0;
    endtask

    task automatic model_edge(input logic [3:0] b);
        logic [3:0] s;
        s    = m_q2;
        m_q2 = m_q1;
        m_q1 = b;
        m_jog = 0;
        m_inv = 0;
        case (m_phase)
            0: begin
                if (s == 0) m_run = 0;
                else if (m_run > 0 && s == m_pat) m_run++;
                else begin m_pat = s; m_run = 1; end
                if (m_run == int'(D) + 1) begin
                    if ($countones(m_pat) == 1) begin m_jog = 1; m_val = m_pat; end
                    else m_inv = 1;
                    m_phase = 1;
                end
            end
            1: begin m_phase = 2; m_zrun = 0; end
            default: begin
                if (s == 0) m_zrun++; else m_zrun = 0;
                if (m_zrun == int'(D) + 1) begin m_phase = 0; m_run = 0; end
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".jogada"},   {3'b000, jogada},   {3'b000, m_jog});
        chk({tag, ".invalida"}, {3'b000, invalida}, {3'b000, m_inv});
        chk({tag, ".valor"},    jogada_valor,       m_val);
        chk({tag, ".estado"},   db_estado,          exp_db());
        chk({tag, ".exclusive"}, {3'b000, jogada & invalida}, 4'b0000);
        if (jogada === 1'b1) n_jog++;
        if (invalida === 1'b1) n_inv++;
    endtask

    // called at a negedge; returns at the following negedge
    task automatic step(input logic [3:0] b, input string tag);
        botoes = b;
        @(posedge clock);
        model_edge(b);
        #1;
        compare_all(tag);
        @(negedge clock);
    endtask

    task automatic hold(input logic [3:0] b, input int n, input string tag);
        for (int i = 0; i < n; i++) step(b, tag);
    endtask

    // asynchronous reset pulse spanning one rising edge
    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        compare_all({tag, ".async"});
        @(posedge clock);
        #1;
        compare_all({tag, ".held"});
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int base_j, base_i, first;
        logic [3:0] pat;
        int len, r;

        reset  = 1'b1;
        botoes = 4'b0000;
        model_reset();
        @(negedge clock);
        compare_all("reset_state");
        reset = 1'b0;
        hold(4'b0000, 3, "idle");

        // single press held: one pulse at t0+D+2, value 0010
        base_j = n_jog;
        hold(4'b0010, 20, "press_0010");
        chk_int("press_0010.count", n_jog - base_j, 1);
        chk("press_0010.final_valor", jogada_valor, 4'b0010);
        hold(4'b0000, 8, "release_0010");

        // short press rejected silently
        base_j = n_jog;
        hold(4'b0100, 3, "short_0100");
        hold(4'b0000, 6, "short_release");
        chk_int("short_0100.count", n_jog - base_j, 0);
        chk("short_0100.estado", db_estado, 4'h0);
        chk("short_0100.valor", jogada_valor, 4'b0010);

        // multi-button pattern gives invalida only
        base_j = n_jog; base_i = n_inv;
        hold(4'b1001, 20, "multi_1001");
        chk_int("multi_1001.inv_count", n_inv - base_i, 1);
        chk_int("multi_1001.jog_count", n_jog - base_j, 0);
        chk("multi_1001.valor", jogada_valor, 4'b0010);
        hold(4'b0000, 8, "release_1001");

        // bouncing contact followed by a stable press
        base_j = n_jog;
        for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 4'b0001 : 4'b0000, "bounce");
        hold(4'b0001, 10, "bounce_hold");
        chk_int("bounce.count", n_jog - base_j, 1);
        chk("bounce.valor", jogada_valor, 4'b0001);
        hold(4'b0000, 8, "release_bounce");

        // short release does not re-arm the detector
        base_j = n_jog;
        hold(4'b1000, 10, "rearm_first");
        hold(4'b0000, 2, "rearm_gap");
        hold(4'b1000, 20, "rearm_second");
        chk_int("rearm.count_short_gap", n_jog - base_j, 1);
        hold(4'b0000, 8, "rearm_release");
        hold(4'b1000, 10, "rearm_third");
        chk_int("rearm.count_full_gap", n_jog - base_j, 2);
        hold(4'b0000, 8, "release_1000");

        // reset while filtering aborts; held button is a new press afterwards
        hold(4'b0001, 3, "filter_0001");
        chk("filter_0001.estado", db_estado, 4'h1);
        botoes = 4'b0001;
        pulse_reset("mid_filter");
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            step(4'b0001, "post_reset");
            if (jogada === 1'b1 && first < 0) first = i;
        end
        chk_int("post_reset.latency", first, int'(D) + 3);
        chk("post_reset.valor", jogada_valor, 4'b0001);
        hold(4'b0000, 8, "release_post_reset");

        // random traffic with occasional resets
        for (int seg = 0; seg < 300; seg++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3) pat = 4'b0000;
            else if (r < 7) pat = 4'(1 << $urandom_range(0, 3));
            else pat = 4'($urandom_range(1, 15));
            len = int'($urandom_range(1, 9));
            if ($urandom_range(0, 39) == 0) begin
                botoes = pat;
                pulse_reset("rand_reset");
            end
            hold(pat, len, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
